// File: rtl/sc_phase_sequencer.sv
// Two-phase non-overlapping clock sequencer for switched-capacitor front ends.
// Optional macro SC_EARLY_PHASE_EN makes phi1e/phi2e fall one cycle before phi1/phi2.
module sc_phase_sequencer #(
    parameter int PW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_load,
    input  logic [PW-1:0] phase_len,
    input  logic [DW-1:0] dead_len,
    output logic          phi1,
    output logic          phi2,
    output logic          phi1e,
    output logic          phi2e,
    output logic          busy,
    output logic          period_done
);

    localparam int CW = (PW > DW) ? PW : DW;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PHI1   = 3'd1;
    localparam logic [2:0] DEAD12 = 3'd2;
    localparam logic [2:0] PHI2   = 3'd3;
    localparam logic [2:0] DEAD21 = 3'd4;

    logic [2:0]    state, n_state;
    logic [CW-1:0] cnt, n_cnt;
    logic [PW-1:0] ph_sh, cur_ph, n_ph, ent_ph;
    logic [DW-1:0] dl_sh, cur_dl, n_dl, ent_dl;
    logic          n_phi1e, n_phi2e;

    // Counter loads length-1 with a zero length treated as one cycle.
    function automatic logic [CW-1:0] ph_m1(input logic [PW-1:0] v);
        ph_m1 = (v == '0) ? '0 : CW'(v - PW'(1));
    endfunction

    function automatic logic [CW-1:0] dl_m1(input logic [DW-1:0] v);
        dl_m1 = (v == '0) ? '0 : CW'(v - DW'(1));
    endfunction

    // A load coinciding with PHI1 entry must apply to that very period.
    assign ent_ph = cfg_load ? phase_len : ph_sh;
    assign ent_dl = cfg_load ? dead_len  : dl_sh;

    always_comb begin
        n_state = state;
        n_cnt   = (cnt != '0) ? cnt - CW'(1) : '0;
        n_ph    = cur_ph;
        n_dl    = cur_dl;
        case (state)
            IDLE: begin
                if (en) begin
                    n_state = PHI1;
                    n_ph    = ent_ph;
                    n_dl    = ent_dl;
                    n_cnt   = ph_m1(ent_ph);
                end
            end
            PHI1: begin
                if (cnt == '0) begin
                    n_state = DEAD12;
                    n_cnt   = dl_m1(cur_dl);
                end
            end
            DEAD12: begin
                if (cnt == '0) begin
                    n_state = PHI2;
                    n_cnt   = ph_m1(cur_ph);
                end
            end
            PHI2: begin
                if (cnt == '0) begin
                    n_state = DEAD21;
                    n_cnt   = dl_m1(cur_dl);
                end
            end
            DEAD21: begin
                if (cnt == '0) begin
                    if (en) begin
                        n_state = PHI1;
                        n_ph    = ent_ph;
                        n_dl    = ent_dl;
                        n_cnt   = ph_m1(ent_ph);
                    end else begin
                        n_state = IDLE;
                        n_cnt   = '0;
                    end
                end
            end
            default: begin
                n_state = IDLE;
                n_cnt   = '0;
            end
        endcase
    end

`ifdef SC_EARLY_PHASE_EN
    always_comb begin
        n_phi1e = (n_state == PHI1) && ((n_cnt != '0) || (n_ph <= PW'(1)));
        n_phi2e = (n_state == PHI2) && ((n_cnt != '0) || (n_ph <= PW'(1)));
    end
`else
    always_comb begin
        n_phi1e = (n_state == PHI1);
        n_phi2e = (n_state == PHI2);
    end
`endif

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ph_sh       <= PW'(1);
            dl_sh       <= DW'(1);
            cur_ph      <= PW'(1);
            cur_dl      <= DW'(1);
            phi1        <= 1'b0;
            phi2        <= 1'b0;
            phi1e       <= 1'b0;
            phi2e       <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state  <= n_state;
            cnt    <= n_cnt;
            cur_ph <= n_ph;
            cur_dl <= n_dl;
            if (cfg_load) begin
                ph_sh <= phase_len;
                dl_sh <= dead_len;
            end
            phi1        <= (n_state == PHI1);
            phi2        <= (n_state == PHI2);
            phi1e       <= n_phi1e;
            phi2e       <= n_phi2e;
            busy        <= (n_state != IDLE);
            period_done <= (n_state == DEAD21) && (n_cnt == '0);
        end
    end

endmodule

// File: doc/sc_phase_sequencer.md
SC_PHASE_SEQUENCER -- requirements
Module: sc_phase_sequencer

Interface
REQ-001 SHALL have parameter PW, default 8: width of the phase-length count.
REQ-002 SHALL have parameter DW, default 4: width of the dead-time count.
REQ-003 SHALL have input clk, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input en, 1 bit: level request to run phi1/phi2 periods.
REQ-006 SHALL have input cfg_load, 1 bit: single-cycle strobe that captures phase_len and dead_len into shadow registers.
REQ-007 SHALL have input phase_len, PW bits: high time of each phase, in clk cycles.
REQ-008 SHALL have input dead_len, DW bits: non-overlap gap between phases, in clk cycles.
REQ-009 SHALL have output phi1, 1 bit: registered switch drive for the sampling-phase NMOS switches.
REQ-010 SHALL have output phi2, 1 bit: registered switch drive for the transfer-phase NMOS switches.
REQ-011 SHALL have outputs phi1e and phi2e, 1 bit each: registered early-phase (bottom-plate) versions of phi1 and phi2.
REQ-012 SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-013 SHALL have output period_done, 1 bit: single-cycle pulse marking the end of each full period.

Function
REQ-014 SHALL implement FSM states IDLE, PHI1, DEAD12, PHI2 and DEAD21; each state holds a down-counter.
REQ-015 Transitions SHALL be as follows:
- IDLE to PHI1 when en=1.
- PHI1 to DEAD12, DEAD12 to PHI2, and PHI2 to DEAD21, each when the counter expires.
- DEAD21 to PHI1 if en=1, otherwise DEAD21 to IDLE.
REQ-016 phi1 SHALL be 1 only in PHI1, and phi2 only in PHI2; phi1 and phi2 SHALL never both be 1 in any cycle.
REQ-017 Latency: if en is sampled 1 in IDLE at edge t, phi1 SHALL be 1 from the cycle after edge t.
REQ-018 PHI1 and PHI2 SHALL each last exactly eff_phase cycles, where eff_phase = max(phase_len_shadow, 1).
REQ-019 DEAD12 and DEAD21 SHALL each last exactly eff_dead cycles, where eff_dead = max(dead_len_shadow, 1); a zero dead time is never produced.
REQ-020 Shadow configuration SHALL be applied only on entry to PHI1; a cfg_load mid-period SHALL NOT alter the period in progress.
REQ-021 If cfg_load is asserted in the same cycle as entry to PHI1, the newly loaded values SHALL apply to that period.
REQ-022 en deasserting mid-period SHALL NOT truncate any phase; the FSM completes through DEAD21 and then returns to IDLE.
REQ-023 period_done SHALL be 1 in the last cycle of DEAD21, including the final period before IDLE.
REQ-024 Counters SHALL saturate rather than wrap; PW-bit and DW-bit maximums (255 and 15 at defaults) SHALL be legal.

Reset
REQ-025 While rst_n=0, the FSM SHALL be IDLE and phi1, phi2, phi1e, phi2e, busy and period_done SHALL all be 0, asynchronously.
REQ-026 While rst_n=0, the phase_len shadow SHALL reset to 1 and the dead_len shadow SHALL reset to 1.
REQ-027 Reset asserted mid-phase SHALL force both phases low immediately, with no completion of the current period.
REQ-028 After rst_n releases, the first transition out of IDLE SHALL require en sampled 1 on a clk edge.

Configuration
REQ-029 Macro SC_EARLY_PHASE_EN SHALL control the early-phase outputs.
REQ-030 With SC_EARLY_PHASE_EN defined:
- phi1e rises with phi1 and falls one cycle before phi1 when eff_phase >= 2.
- phi2e behaves the same way relative to phi2.
- When eff_phase = 1, phi1e = phi1 and phi2e = phi2.
REQ-031 Without SC_EARLY_PHASE_EN, phi1e SHALL equal phi1 and phi2e SHALL equal phi2 in every cycle.

Verification
REQ-032 Basic timing: reset, cfg_load with phase_len=4 and dead_len=2, then en=1. Required: phi1 high 4 cycles, 2-cycle gap, phi2 high 4 cycles, 2-cycle gap; period of 12 cycles; period_done every 12th cycle.
REQ-033 Zero configuration: phase_len=0 and dead_len=0. Required: each phase 1 cycle, each gap 1 cycle; phi1 and phi2 never both high.
REQ-034 Mid-period load and graceful stop:
- cfg_load phase_len=6 during PHI2 of a phase_len=4 period: current PHI2 stays at 4 cycles, next PHI1 is 6 cycles.
- en dropped during PHI1: that period completes, period_done pulses once, then IDLE with busy=0.
REQ-035 Reset mid-operation: rst_n=0 mid-PHI2 with phase_len=8. Required: phi2=0 without waiting for a clock edge; after release, IDLE until en is sampled 1.
REQ-036 SC_EARLY_PHASE_EN defined, phase_len=5: phi1e high 4 cycles and phi1 high 5 cycles, both rising together. With phase_len=1: phi1e = phi1.
REQ-037 Maximum values: phase_len=255, dead_len=15. Required: 540-cycle period; checker confirms no overlap across 10 periods.
